window_reverse_buf: RTL and testbench



---
 rtl/window_reverse_pkg.sv | 29 ++
 rtl/window_bank_ram.sv | 41 ++++
 rtl/window_reverse_buf.sv | 168 ++++++++++++++++
 tb/tb_window_reverse_buf.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/window_reverse_pkg.sv
// rtl/window_reverse_pkg.sv - shared types and default sizes for the window reversal buffer
package window_reverse_pkg;

    localparam int DEF_D_WID   = 32;
    localparam int DEF_WIN_LEN = 64;
    // Width of the stored window length; covers any practical WIN_LEN
    localparam int LEN_W       = 16;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_state_e;

    typedef struct packed {
        bank_state_e      state;
        logic [LEN_W-1:0] len;
        logic             blk;
    } bank_stat_t;

    localparam bank_stat_t BANK_RST = '{state: EMPTY, len: '0, blk: 1'b0};

    // A bank holds a complete window that the read side may consume
    function automatic logic is_readable(bank_state_e s);
        return (s == FULL) || (s == DRAINING);
    endfunction

endpackage

// File: rtl/window_bank_ram.sv
// rtl/window_bank_ram.sv - two single-port read-first RAM banks with registered, holding outputs
module window_bank_ram #(
    parameter int D_WID = 32,
    parameter int A_WID = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         ena_i,
    input  logic [1:0]         we_i,
    input  logic [2*A_WID-1:0] addr_i,
    input  logic [2*D_WID-1:0] din_i,
    output logic [2*D_WID-1:0] dout_o
);

    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic [D_WID-1:0] mem_q [2**A_WID];
        logic [D_WID-1:0] dout_q;
        logic [A_WID-1:0] addr;

        assign addr = addr_i[b*A_WID +: A_WID];

        // Storage array; contents survive reset
        always_ff @(posedge clk) begin
            if (ena_i[b] && we_i[b]) begin
                mem_q[addr] <= din_i[b*D_WID +: D_WID];
            end
        end

        // Read-first output register, held whenever the bank is not enabled
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dout_q <= '0;
            end else if (ena_i[b]) begin
                dout_q <= mem_q[addr];
            end
        end

        assign dout_o[b*D_WID +: D_WID] = dout_q;
    end

endmodule

// File: rtl/window_reverse_buf.sv
// rtl/window_reverse_buf.sv - ping-pong window reversal buffer; WINDOW_REVERSE_IDX_EN adds m_idx
module window_reverse_buf
    import window_reverse_pkg::*;
#(
    parameter int  D_WID   = DEF_D_WID,
    parameter int  WIN_LEN = DEF_WIN_LEN,
    localparam int A_WID   = $clog2(WIN_LEN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [D_WID-1:0] s_data,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [D_WID-1:0] m_data,
    output logic             m_last_win,
    output logic             m_last_blk
`ifdef WINDOW_REVERSE_IDX_EN
   ,output logic [A_WID-1:0] m_idx
`endif
);

    localparam logic [A_WID-1:0] LAST_ADDR = A_WID'(WIN_LEN - 1);

    bank_stat_t       bank_q [2];
    bank_stat_t       bank_d [2];
    logic             wb_q, wb_d;
    logic             rb_q, rb_d;
    logic             out_bank_q, out_bank_d;
    logic [A_WID-1:0] wcnt_q, wcnt_d;
    logic [A_WID-1:0] raddr_q, raddr_d;
    logic             m_valid_q, m_valid_d;
    logic             m_last_win_q, m_last_win_d;
    logic             m_last_blk_q, m_last_blk_d;

    bank_stat_t       rd_stat;
    logic             wr_fire, wr_close, issue, out_fire;
    logic [A_WID-1:0] iss_addr;

    logic [1:0]         ram_ena, ram_we;
    logic [2*A_WID-1:0] ram_addr;
    logic [2*D_WID-1:0] ram_dout;

    assign rd_stat  = bank_q[rb_q];
    assign wr_fire  = s_valid && s_ready;
    assign wr_close = wr_fire && (s_last || (wcnt_q == LAST_ADDR));
    assign out_fire = m_valid_q && m_ready;
    // Never issue into a stalled output: the held word lives in the RAM output register
    assign issue    = is_readable(rd_stat.state) && (!m_valid_q || m_ready);
    // A fresh bank starts at its top word; a draining one continues downward
    assign iss_addr = (rd_stat.state == FULL) ? A_WID'(rd_stat.len - LEN_W'(1)) : raddr_q;

    // Write bank and read bank are always in disjoint states, so they never collide
    assign ram_we   = {wr_fire && wb_q, wr_fire && !wb_q};
    assign ram_ena  = {ram_we[1] || (issue && rb_q), ram_we[0] || (issue && !rb_q)};
    assign ram_addr = {ram_we[1] ? wcnt_q : iss_addr, ram_we[0] ? wcnt_q : iss_addr};

    window_bank_ram #(
        .D_WID (D_WID),
        .A_WID (A_WID)
    ) u_ram (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena_i  (ram_ena),
        .we_i   (ram_we),
        .addr_i (ram_addr),
        .din_i  ({s_data, s_data}),
        .dout_o (ram_dout)
    );

    // State register for bank status, write/read pointers and output flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_q[0]    <= BANK_RST;
            bank_q[1]    <= BANK_RST;
            wb_q         <= 1'b0;
            rb_q         <= 1'b0;
            out_bank_q   <= 1'b0;
            wcnt_q       <= '0;
            raddr_q      <= '0;
            m_valid_q    <= 1'b0;
            m_last_win_q <= 1'b0;
            m_last_blk_q <= 1'b0;
        end else begin
            bank_q       <= bank_d;
            wb_q         <= wb_d;
            rb_q         <= rb_d;
            out_bank_q   <= out_bank_d;
            wcnt_q       <= wcnt_d;
            raddr_q      <= raddr_d;
            m_valid_q    <= m_valid_d;
            m_last_win_q <= m_last_win_d;
            m_last_blk_q <= m_last_blk_d;
        end
    end

    // Next state: fill/close on the write side, issue/free on the read side
    always_comb begin
        bank_d       = bank_q;
        wb_d         = wb_q;
        rb_d         = rb_q;
        out_bank_d   = out_bank_q;
        wcnt_d       = wcnt_q;
        raddr_d      = raddr_q;
        m_valid_d    = m_valid_q;
        m_last_win_d = m_last_win_q;
        m_last_blk_d = m_last_blk_q;

        if (wr_fire) begin
            if (wr_close) begin
                bank_d[wb_q].state = FULL;
                bank_d[wb_q].len   = LEN_W'(wcnt_q) + LEN_W'(1);
                bank_d[wb_q].blk   = s_last;
                wcnt_d             = '0;
                wb_d               = ~wb_q;
            end else begin
                bank_d[wb_q].state = FILLING;
                wcnt_d             = wcnt_q + A_WID'(1);
            end
        end

        // Free only once the final word has left, so writes cannot disturb the held output
        if (out_fire && m_last_win_q) begin
            bank_d[out_bank_q].state = EMPTY;
        end

        if (issue) begin
            bank_d[rb_q].state = DRAINING;
            raddr_d            = iss_addr - A_WID'(1);
            out_bank_d         = rb_q;
            m_valid_d          = 1'b1;
            m_last_win_d       = (iss_addr == '0);
            m_last_blk_d       = (iss_addr == '0) && rd_stat.blk;
            if (iss_addr == '0) begin
                rb_d = ~rb_q;
            end
        end else if (out_fire) begin
            m_valid_d = 1'b0;
        end
    end

    // Outputs: input readiness from the write bank, data from the bank last read
    always_comb begin
        s_ready    = (bank_q[wb_q].state == EMPTY) || (bank_q[wb_q].state == FILLING);
        m_valid    = m_valid_q;
        m_last_win = m_last_win_q;
        m_last_blk = m_last_blk_q;
        m_data     = out_bank_q ? ram_dout[2*D_WID-1:D_WID] : ram_dout[D_WID-1:0];
    end

`ifdef WINDOW_REVERSE_IDX_EN
    logic [A_WID-1:0] idx_q;

    // Original in-window position, captured with the RAM read and held under stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
        end else if (issue) begin
            idx_q <= iss_addr;
        end
    end

    assign m_idx = idx_q;
`endif

endmodule

// File: tb/tb_window_reverse_buf.sv
// tb/tb_window_reverse_buf.sv - self-checking bench for window_reverse_buf
module tb_window_reverse_buf;

    localparam int WL = 4;
    localparam int DW = 32;
    localparam int AW = 2;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          lw;
        logic          lb;
        logic [AW-1:0] idx;
    } rec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          s_last = 1'b0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_last_win;
    logic          m_last_blk;
`ifdef WINDOW_REVERSE_IDX_EN
    logic [AW-1:0] m_idx;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    rec_t          got_q[$];
    rec_t          exp_q[$];
    logic [DW-1:0] src_d[$];
    logic          src_l[$];

    window_reverse_buf #(.D_WID(DW), .WIN_LEN(WL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last_win (m_last_win),
        .m_last_blk (m_last_blk)
`ifdef WINDOW_REVERSE_IDX_EN
       ,.m_idx      (m_idx)
`endif
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        s_valid = 1'b0;
        s_last  = 1'b0;
        m_ready = 1'b0;
        rst_n   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        got_q.delete();
        exp_q.delete();
        src_d.delete();
        src_l.delete();
    endtask

    task automatic step(output bit inf);
        rec_t r;
        inf = s_valid && s_ready;
        if (m_valid && m_ready) begin
            r.d  = m_data;
            r.lw = m_last_win;
            r.lb = m_last_blk;
`ifdef WINDOW_REVERSE_IDX_EN
            r.idx = m_idx;
`else
            r.idx = '0;
`endif
            got_q.push_back(r);
        end
        @(posedge clk);
        #1;
    endtask

    // Reference: cut the accepted stream into windows and reverse each
    task automatic build_expected();
        logic [DW-1:0] win[$];
        rec_t r;
        exp_q.delete();
        for (int i = 0; i < src_d.size(); i++) begin
            win.push_back(src_d[i]);
            if (win.size() == WL || src_l[i]) begin
                for (int k = win.size() - 1; k >= 0; k--) begin
                    r.d   = win[k];
                    r.lw  = (k == 0);
                    r.lb  = (k == 0) && src_l[i];
                    r.idx = AW'(k);
                    exp_q.push_back(r);
                end
                win.delete();
            end
        end
    endtask

    task automatic run(input int rprob, input int max_cyc);
        int idx = 0;
        int cyc = 0;
        bit inf;
        while ((idx < src_d.size() || got_q.size() < exp_q.size()) && cyc < max_cyc) begin
            if (idx < src_d.size()) begin
                s_valid = 1'b1;
                s_data  = src_d[idx];
                s_last  = src_l[idx];
            end else begin
                s_valid = 1'b0;
                s_data  = $urandom;
                s_last  = 1'($urandom_range(1));
            end
            m_ready = ($urandom_range(99) < rprob);
            step(inf);
            if (inf) idx++;
            cyc++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        m_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks += 5;
        if (s_ready !== 1'b1)    begin n_fail++; $display("FAIL reset s_ready got %b want 1", s_ready); end
        if (m_valid !== 1'b0)    begin n_fail++; $display("FAIL reset m_valid got %b want 0", m_valid); end
        if (m_last_win !== 1'b0) begin n_fail++; $display("FAIL reset m_last_win got %b want 0", m_last_win); end
        if (m_last_blk !== 1'b0) begin n_fail++; $display("FAIL reset m_last_blk got %b want 0", m_last_blk); end
        if (m_data !== '0)       begin n_fail++; $display("FAIL reset m_data got %h want 0", m_data); end
    endtask

    task automatic test_full_windows();
        int want[8] = '{4, 3, 2, 1, 8, 7, 6, 5};
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            src_d.push_back(DW'(i));
            src_l.push_back(1'b0);
        end
        build_expected();
        run(100, 200);
        n_checks++;
        if (got_q.size() != 8) begin n_fail++; $display("FAIL full_win count got %0d want 8", got_q.size()); end
        for (int i = 0; i < 8 && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i].d !== DW'(want[i]) || got_q[i].lw !== (i == 3 || i == 7) || got_q[i].lb !== 1'b0) begin
                n_fail++;
                $display("FAIL full_win[%0d] got d=%0d lw=%b lb=%b want d=%0d lw=%b lb=0",
                         i, got_q[i].d, got_q[i].lw, got_q[i].lb, want[i], (i == 3 || i == 7));
            end
        end
    endtask

    task automatic test_short_block();
        int want[6] = '{4, 3, 2, 1, 6, 5};
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            src_d.push_back(DW'(i));
            src_l.push_back(i == 6);
        end
        build_expected();
        run(100, 200);
        n_checks++;
        if (got_q.size() != 6) begin n_fail++; $display("FAIL short_blk count got %0d want 6", got_q.size()); end
        for (int i = 0; i < 6 && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i].d !== DW'(want[i]) || got_q[i].lw !== (i == 3 || i == 5) || got_q[i].lb !== (i == 5)) begin
                n_fail++;
                $display("FAIL short_blk[%0d] got d=%0d lw=%b lb=%b want d=%0d lw=%b lb=%b",
                         i, got_q[i].d, got_q[i].lw, got_q[i].lb, want[i], (i == 3 || i == 5), (i == 5));
            end
        end
    endtask

    task automatic test_single_word();
        bit inf;
        do_reset();
        s_valid = 1'b1;
        s_data  = 32'hA5;
        s_last  = 1'b1;
        m_ready = 1'b1;
        step(inf);
        s_valid = 1'b0;
        s_last  = 1'b0;
        n_checks += 2;
        if (inf !== 1'b1)     begin n_fail++; $display("FAIL single handshake got %b want 1", inf); end
        if (m_valid !== 1'b0) begin n_fail++; $display("FAIL single early m_valid got %b want 0", m_valid); end
        step(inf);
        n_checks += 4;
        if (m_valid !== 1'b1)     begin n_fail++; $display("FAIL single m_valid got %b want 1", m_valid); end
        if (m_data !== 32'hA5)    begin n_fail++; $display("FAIL single m_data got %h want a5", m_data); end
        if (m_last_win !== 1'b1)  begin n_fail++; $display("FAIL single m_last_win got %b want 1", m_last_win); end
        if (m_last_blk !== 1'b1)  begin n_fail++; $display("FAIL single m_last_blk got %b want 1", m_last_blk); end
        step(inf);
        n_checks++;
        if (m_valid !== 1'b0) begin n_fail++; $display("FAIL single drop m_valid got %b want 0", m_valid); end
        m_ready = 1'b0;
    endtask

    task automatic test_stall();
        int idx = 0;
        int stall_left = 0;
        bit stall_done = 1'b0;
        bit saw_busy = 1'b0;
        bit inf;
        logic [DW-1:0] hold_d = '0;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            src_d.push_back($urandom);
            src_l.push_back(1'b0);
        end
        build_expected();
        for (int cyc = 0; cyc < 300 && got_q.size() < exp_q.size(); cyc++) begin
            s_valid = (idx < 12);
            s_data  = (idx < 12) ? src_d[idx] : '0;
            if (!stall_done && m_valid && got_q.size() == 2) begin
                stall_done = 1'b1;
                stall_left = 3;
                hold_d     = m_data;
            end
            m_ready = (stall_left == 0);
            if (!s_ready) saw_busy = 1'b1;
            step(inf);
            if (inf) idx++;
            if (stall_left > 0) begin
                stall_left--;
                n_checks++;
                if (m_valid !== 1'b1 || m_data !== hold_d) begin
                    n_fail++;
                    $display("FAIL stall hold got v=%b d=%h want v=1 d=%h", m_valid, m_data, hold_d);
                end
            end
        end
        s_valid = 1'b0;
        m_ready = 1'b0;
        n_checks += 3;
        if (stall_done !== 1'b1) begin n_fail++; $display("FAIL stall never entered got 0 want 1"); end
        if (saw_busy !== 1'b1)   begin n_fail++; $display("FAIL stall s_ready never low got 0 want 1"); end
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL stall count got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i].d !== exp_q[i].d || got_q[i].lw !== exp_q[i].lw || got_q[i].lb !== exp_q[i].lb) begin
                n_fail++;
                $display("FAIL stall seq[%0d] got d=%h lw=%b lb=%b want d=%h lw=%b lb=%b", i,
                         got_q[i].d, got_q[i].lw, got_q[i].lb, exp_q[i].d, exp_q[i].lw, exp_q[i].lb);
            end
        end
    endtask

    task automatic test_mid_reset();
        int idx = 0;
        int want[4] = '{12, 11, 10, 9};
        bit inf;
        do_reset();
        m_ready = 1'b1;
        for (int cyc = 0; cyc < 50 && idx < 6; cyc++) begin
            s_valid = 1'b1;
            s_data  = DW'(idx + 1);
            step(inf);
            if (inf) idx++;
        end
        s_valid = 1'b0;
        m_ready = 1'b0;
        rst_n   = 1'b0;
        #1;
        n_checks += 3;
        if (m_valid !== 1'b0) begin n_fail++; $display("FAIL midrst m_valid got %b want 0", m_valid); end
        if (s_ready !== 1'b1) begin n_fail++; $display("FAIL midrst s_ready got %b want 1", s_ready); end
        if (m_data !== '0)    begin n_fail++; $display("FAIL midrst m_data got %h want 0", m_data); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        got_q.delete();
        src_d.delete();
        src_l.delete();
        for (int i = 9; i <= 12; i++) begin
            src_d.push_back(DW'(i));
            src_l.push_back(1'b0);
        end
        build_expected();
        run(100, 200);
        n_checks++;
        if (got_q.size() != 4) begin n_fail++; $display("FAIL midrst count got %0d want 4", got_q.size()); end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i].d !== DW'(want[i]) || got_q[i].lw !== (i == 3) || got_q[i].lb !== 1'b0) begin
                n_fail++;
                $display("FAIL midrst[%0d] got d=%0d lw=%b lb=%b want d=%0d lw=%b lb=0",
                         i, got_q[i].d, got_q[i].lw, got_q[i].lb, want[i], (i == 3));
            end
        end
    endtask

    task automatic test_random_stream();
        do_reset();
        for (int i = 0; i < 1000; i++) begin
            src_d.push_back($urandom);
            src_l.push_back(($urandom_range(9) == 0) || (i == 999));
        end
        build_expected();
        run(70, 20000);
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL random count got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i].d !== exp_q[i].d || got_q[i].lw !== exp_q[i].lw || got_q[i].lb !== exp_q[i].lb) begin
                n_fail++;
                $display("FAIL random[%0d] got d=%h lw=%b lb=%b want d=%h lw=%b lb=%b", i,
                         got_q[i].d, got_q[i].lw, got_q[i].lb, exp_q[i].d, exp_q[i].lw, exp_q[i].lb);
            end
`ifdef WINDOW_REVERSE_IDX_EN
            n_checks++;
            if (got_q[i].idx !== exp_q[i].idx) begin
                n_fail++;
                $display("FAIL random idx[%0d] got %0d want %0d", i, got_q[i].idx, exp_q[i].idx);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_full_windows();
        test_short_block();
        test_single_word();
        test_stall();
        test_mid_reset();
        test_random_stream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
